// File: rtl/verif_relojes_if.sv
// Bundle between the divided-clock sources and the clock-chain monitor:
// clocks under test and re-acquire pulse in, lock/error status and periods out.
interface verif_relojes_if;
  logic       clk_4f;
  logic       clk_2f;
  logic       clk_f;
  logic       clr_err;
  logic       lock;
  logic       err;
  logic [2:0] err_src;
  logic [7:0] per_4f;
  logic [7:0] per_2f;
  logic [7:0] per_f;

  modport master (
    output clk_4f, clk_2f, clk_f, clr_err,
    input  lock, err, err_src, per_4f, per_2f, per_f
  );

  modport slave (
    input  clk_4f, clk_2f, clk_f, clr_err,
    output lock, err, err_src, per_4f, per_2f, per_f
  );
endinterface

// File: rtl/verif_relojes.sv
// Clock-chain self-check: measures the 4f/2f/f periods in clk_in cycles,
// locks once every channel has LOCK_COUNT good periods, then latches drift/stop errors.

module verif_relojes_chan #(
  parameter int PEXP       = 6,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk_in,
  input  logic       reset_L,
  input  logic       clk_x,
  input  logic       restart,
  output logic [7:0] per,
  output logic       bad,
  output logic       full
);
  localparam int         LO   = (PEXP > TOL) ? PEXP - TOL : 0;
  localparam int         HI   = (PEXP + TOL > 255) ? 255 : PEXP + TOL;
  localparam logic [7:0] LO8  = 8'(LO);
  localparam logic [7:0] HI8  = 8'(HI);
  localparam logic [7:0] TMO8 = 8'(2 * PEXP);
  localparam logic [3:0] LC4  = 4'(LOCK_COUNT);

  logic       prev, armed, rise, in_tol, good;
  logic [7:0] cnt;
  logic [3:0] good_cnt;

  // cnt equals the elapsed period on the cycle a rise is seen
  assign rise   = clk_x & ~prev;
  assign in_tol = (cnt >= LO8) && (cnt <= HI8);
  assign good   = armed & rise & in_tol;
  assign bad    = armed & ((rise & ~in_tol) | (~rise & (cnt == TMO8)));
  assign full   = (good_cnt == LC4);

  always_ff @(posedge clk_in) begin
    if (!reset_L) begin
      prev     <= 1'b0;
      cnt      <= '0;
      armed    <= 1'b0;
      per      <= '0;
      good_cnt <= '0;
    end else begin
      prev <= clk_x;
      if (rise)              cnt <= 8'd1;
      else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (armed && rise) per <= cnt;
      if (restart) begin
        armed    <= 1'b0;
        good_cnt <= '0;
      end else begin
        if (rise) armed <= 1'b1;
        if (bad)                good_cnt <= '0;
        else if (good && !full) good_cnt <= good_cnt + 4'd1;
      end
    end
  end
endmodule

module verif_relojes #(
  parameter int BASE_DIV   = 6,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic           clk_in,
  input  logic           reset_L,
  verif_relojes_if.slave bus
);
  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {ACQUIRE, LOCKED, ERROR} state_t;

  state_t                        state, state_nxt;
  logic [NUM_CH-1:0]             clk_v, bad_v, full_v;
  logic [NUM_CH-1:0][7:0]        per_v;
  logic [NUM_CH-1:0]             err_src_q, err_src_nxt;
  logic                          restart;

  assign clk_v   = {bus.clk_f, bus.clk_2f, bus.clk_4f};
  assign restart = (state == ERROR) && bus.clr_err;

  // channel g expects BASE_DIV * 2^g clk_in cycles per period
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    verif_relojes_chan #(
      .PEXP      (BASE_DIV * (1 << g)),
      .TOL       (TOL),
      .LOCK_COUNT(LOCK_COUNT)
    ) u_chan (
      .clk_in (clk_in),
      .reset_L(reset_L),
      .clk_x  (clk_v[g]),
      .restart(restart),
      .per    (per_v[g]),
      .bad    (bad_v[g]),
      .full   (full_v[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (!reset_L) begin
      state     <= ACQUIRE;
      err_src_q <= '0;
    end else begin
      state     <= state_nxt;
      err_src_q <= err_src_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    err_src_nxt = err_src_q;
    case (state)
      ACQUIRE: if (&full_v) state_nxt = LOCKED;
      LOCKED: begin
        if (|bad_v) begin
          state_nxt   = ERROR;
          err_src_nxt = bad_v;
        end
      end
      ERROR: begin
        // a re-acquire request beats a coincident new failure
        if (bus.clr_err) begin
          state_nxt   = ACQUIRE;
          err_src_nxt = '0;
        end else begin
          err_src_nxt = err_src_q | bad_v;
        end
      end
      default: state_nxt = ACQUIRE;
    endcase
  end

  assign bus.lock    = (state == LOCKED);
  assign bus.err     = (state == ERROR);
  assign bus.err_src = err_src_q;
  assign bus.per_4f  = per_v[0];
  assign bus.per_2f  = per_v[1];
  assign bus.per_f   = per_v[2];
endmodule

// File: tb/tb_verif_relojes.sv
// Directed bench for verif_relojes: drives 4f/2f/f square waves from clk_in,
// with per-channel period overrides and hold-low, and checks lock/error timing.
module tb_verif_relojes;
  logic clk_in;
  logic reset_L;
  verif_relojes_if bus ();

  verif_relojes #(.BASE_DIV(6), .LOCK_COUNT(4), .TOL(0)) u_dut (
    .clk_in (clk_in),
    .reset_L(reset_L),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int s0       = 0;
  int nom[3], cur[3], ph[3], os[3];
  bit hold[3];
  bit chv[3];
  bit seen_err, seen_lock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, cyc - s0);
    end
  endtask

  // one clk_in cycle: outputs of the last edge are sampled, then the clocks advance
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      ph[i]++;
      if (ph[i] >= cur[i]) begin
        ph[i] = 0;
        if (os[i] != 0) begin
          cur[i] = os[i];
          os[i]  = 0;
        end else begin
          cur[i] = nom[i];
        end
      end
      chv[i] = !hold[i] && (ph[i] < cur[i] / 2);
    end
    bus.clk_4f = chv[0];
    bus.clk_2f = chv[1];
    bus.clk_f  = chv[2];
    if (bus.err)  seen_err  = 1'b1;
    if (bus.lock) seen_lock = 1'b1;
  endtask

  task automatic run_to(input int t);
    while (cyc < s0 + t) tick();
  endtask

  initial begin
    reset_L     = 1'b0;
    bus.clr_err = 1'b0;
    bus.clk_4f  = 1'b0;
    bus.clk_2f  = 1'b0;
    bus.clk_f   = 1'b0;
    nom[0] = 6; nom[1] = 12; nom[2] = 24;
    for (int i = 0; i < 3; i++) begin
      cur[i] = nom[i]; ph[i] = 0; os[i] = 0; hold[i] = 1'b1;
    end
    repeat (3) tick();
    chk("rst_lock",    8'(bus.lock),    8'd0);
    chk("rst_err",     8'(bus.err),     8'd0);
    chk("rst_err_src", 8'(bus.err_src), 8'd0);
    chk("rst_per_4f",  bus.per_4f,      8'd0);
    chk("rst_per_2f",  bus.per_2f,      8'd0);
    chk("rst_per_f",   bus.per_f,       8'd0);

    // all three clocks rise together on tick 0
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hold[i] = 1'b0; ph[i] = nom[i] - 1; cur[i] = nom[i];
    end
    tick();
    s0 = cyc;
    seen_err = 0; seen_lock = 0;

    // nominal: 4th good f period is loaded on edge 97, lock follows one cycle later
    run_to(97);
    chk("nom_no_early_lock", 8'(seen_lock), 8'd0);
    chk("nom_no_err",        8'(seen_err),  8'd0);
    chk("nom_per_4f",        bus.per_4f,    8'd6);
    chk("nom_per_2f",        bus.per_2f,    8'd12);
    chk("nom_per_f",         bus.per_f,     8'd24);
    run_to(98);
    chk("nom_lock", 8'(bus.lock), 8'd1);

    // one 7-cycle 4f period starting at tick 102, measured on edge 110
    os[0] = 7;
    run_to(109);
    chk("str_pre_lock", 8'(bus.lock), 8'd1);
    run_to(110);
    chk("str_lock",    8'(bus.lock),    8'd0);
    chk("str_err",     8'(bus.err),     8'd1);
    chk("str_err_src", 8'(bus.err_src), 8'd1);
    chk("str_per_4f",  bus.per_4f,      8'd7);

    // clear in ERROR on edge 125; f re-arms on edge 145, goods end on edge 241
    run_to(124);
    bus.clr_err = 1'b1;
    run_to(125);
    bus.clr_err = 1'b0;
    chk("clr_err",     8'(bus.err),     8'd0);
    chk("clr_err_src", 8'(bus.err_src), 8'd0);
    chk("clr_lock",    8'(bus.lock),    8'd0);
    seen_lock = 0;
    run_to(241);
    chk("relock_early", 8'(seen_lock), 8'd0);
    run_to(242);
    chk("relock", 8'(bus.lock), 8'd1);

    // f held low after its edge-241 rise: cnt hits 48 after edge 288
    hold[2] = 1'b1;
    run_to(245);
    bus.clr_err = 1'b1;
    run_to(246);
    bus.clr_err = 1'b0;
    chk("clr_ignored_locked", 8'(bus.lock), 8'd1);
    run_to(288);
    chk("stop_pre_err",  8'(bus.err),  8'd0);
    chk("stop_pre_lock", 8'(bus.lock), 8'd1);
    run_to(289);
    chk("stop_err",     8'(bus.err),     8'd1);
    chk("stop_err_src", 8'(bus.err_src), 8'h4);
    chk("stop_lock",    8'(bus.lock),    8'd0);

    run_to(300);
    hold[2] = 1'b0;
    run_to(302);
    bus.clr_err = 1'b1;
    run_to(303);
    bus.clr_err = 1'b0;
    chk("clr2_err",     8'(bus.err),     8'd0);
    chk("clr2_err_src", 8'(bus.err_src), 8'd0);

    // acquire: a 13-cycle 2f period (edge 398) pushes lock from 410 to 447
    run_to(373);
    os[1] = 13;
    seen_err = 0; seen_lock = 0;
    run_to(398);
    chk("inj_per_2f", bus.per_2f, 8'd13);
    run_to(446);
    chk("inj_no_lock", 8'(seen_lock), 8'd0);
    chk("inj_no_err",  8'(seen_err),  8'd0);
    run_to(447);
    chk("inj_lock", 8'(bus.lock), 8'd1);

    // one-cycle reset while locked; f re-arms on edge 457, relock at 554
    run_to(450);
    reset_L = 1'b0;
    run_to(451);
    reset_L = 1'b1;
    chk("mrst_lock",    8'(bus.lock),    8'd0);
    chk("mrst_err",     8'(bus.err),     8'd0);
    chk("mrst_err_src", 8'(bus.err_src), 8'd0);
    chk("mrst_per_4f",  bus.per_4f,      8'd0);
    chk("mrst_per_2f",  bus.per_2f,      8'd0);
    chk("mrst_per_f",   bus.per_f,       8'd0);
    seen_lock = 0;
    run_to(553);
    chk("mrst_no_early_lock", 8'(seen_lock), 8'd0);
    chk("mrst_per_f_relock",  bus.per_f,     8'd24);
    chk("mrst_per_2f_relock", bus.per_2f,    8'd12);
    run_to(554);
    chk("mrst_relock", 8'(bus.lock), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
